// File: rtl/reg_bank_ab.sv
// ============================================================================
// Module      : reg_bank_ab
// Description : 32-entry general-purpose register bank with two read ports
//               feeding registered A/B operand latches and one write port.
//               Register 0 reads as zero, register 29 resets to SP_RESET and
//               register 31 resets to RA_RESET.
//               Optional macro REG_BANK_WRITE_BYPASS_EN: a same-edge write to
//               a register being latched forwards WriteData into A/B.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank_ab #(
   parameter int                 DATA_W   = 32,
   parameter logic [DATA_W-1:0]  SP_RESET = 227,
   parameter logic [DATA_W-1:0]  RA_RESET = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [4:0]        WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [4:0]        ReadReg1,
   input  logic [4:0]        ReadReg2,
   input  logic              LoadAB,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              WriteBusy
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      COMMIT = 1'b1
   } state_t;

   logic [DATA_W-1:0] r_regs [0:31];
   state_t            r_state;

   logic              w_write_en;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic              w_byp1;
   logic              w_byp2;

   // A write only counts when it targets a real register.
   assign w_write_en = RegWrite && (WriteReg != 5'd0);

   // Combinational read ports; index 0 is forced to zero regardless of storage.
   always_comb begin
      w_rd1 = '0;
      w_rd2 = '0;
      if (ReadReg1 != 5'd0) w_rd1 = r_regs[ReadReg1];
      if (ReadReg2 != 5'd0) w_rd2 = r_regs[ReadReg2];
   end

   // Same-edge forwarding select; disabled builds capture the pre-write value.
   always_comb begin
`ifdef REG_BANK_WRITE_BYPASS_EN
      w_byp1 = w_write_en && (WriteReg == ReadReg1);
      w_byp2 = w_write_en && (WriteReg == ReadReg2);
`else
      w_byp1 = 1'b0;
      w_byp2 = 1'b0;
`endif
   end

   // Register storage: reset loads the architectural initial values, then writes commit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            if (i == 29)      r_regs[i] <= SP_RESET;
            else if (i == 31) r_regs[i] <= RA_RESET;
            else              r_regs[i] <= '0;
         end
      end else if (w_write_en) begin
         r_regs[WriteReg] <= WriteData;
      end
   end

   // Operand latches: capture both read ports on LoadAB, otherwise hold.
   always_ff @(posedge clk) begin
      if (!reset) begin
         A <= '0;
         B <= '0;
      end else if (LoadAB) begin
         A <= w_byp1 ? WriteData : w_rd1;
         B <= w_byp2 ? WriteData : w_rd2;
      end
   end

   // Write-commit tracker: busy for the cycle following each committed write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= IDLE;
         WriteBusy <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_write_en) begin
                  r_state   <= COMMIT;
                  WriteBusy <= 1'b1;
               end else begin
                  r_state   <= IDLE;
                  WriteBusy <= 1'b0;
               end
            end
            COMMIT: begin
               if (w_write_en) begin
                  r_state   <= COMMIT;
                  WriteBusy <= 1'b1;
               end else begin
                  r_state   <= IDLE;
                  WriteBusy <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               WriteBusy <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_ab.sv
// ============================================================================
// Module      : tb_reg_bank_ab
// Description : Self-checking bench for reg_bank_ab. Expected A/B pairs are
//               queued when LoadAB is driven and compared one edge later.
//               Honours REG_BANK_WRITE_BYPASS_EN for the same-edge case.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_bank_ab;

   localparam int DATA_W = 32;

   typedef struct {
      string             tag;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              RegWrite;
   logic [4:0]        WriteReg;
   logic [DATA_W-1:0] WriteData;
   logic [4:0]        ReadReg1;
   logic [4:0]        ReadReg2;
   logic              LoadAB;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic              WriteBusy;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   reg_bank_ab #(
      .DATA_W   (DATA_W),
      .SP_RESET (32'd227),
      .RA_RESET (32'd0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .RegWrite  (RegWrite),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .LoadAB    (LoadAB),
      .A         (A),
      .B         (B),
      .WriteBusy (WriteBusy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pop every queued expectation and compare against the latches.
   task automatic drain();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({e.tag, "_A"}, A, e.a);
         chk({e.tag, "_B"}, B, e.b);
      end
   endtask

   // Drive LoadAB for one edge (any write set up by the caller shares that edge).
   task automatic load(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb);
      exp_t e;
      ReadReg1 = r1;
      ReadReg2 = r2;
      LoadAB   = 1'b1;
      e.tag = tag;
      e.a   = ea;
      e.b   = eb;
      exp_q.push_back(e);
      step();
      LoadAB   = 1'b0;
      RegWrite = 1'b0;
      drain();
   endtask

   task automatic write(input logic [4:0] idx, input logic [DATA_W-1:0] data);
      RegWrite  = 1'b1;
      WriteReg  = idx;
      WriteData = data;
      step();
      RegWrite  = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] exp_same;

      reset     = 1'b0;
      RegWrite  = 1'b1;
      WriteReg  = 5'd7;
      WriteData = 32'hFFFF_FFFF;
      ReadReg1  = 5'bxxxxx;
      ReadReg2  = 5'bxxxxx;
      LoadAB    = 1'b1;
      step();
      step();
      RegWrite  = 1'b0;
      LoadAB    = 1'b0;
      chk("rst_A", A, 32'd0);
      chk("rst_B", B, 32'd0);
      chk("rst_busy", {31'd0, WriteBusy}, 32'd0);

      reset = 1'b1;
      step();
      chk("xsafe_A", A, 32'd0);
      chk("xsafe_B", B, 32'd0);

      // Reset values, including sweep of all indices.
      load("sp_zero", 5'd29, 5'd0, 32'd227, 32'd0);
      for (int i = 1; i < 32; i++) begin
         load($sformatf("sweep%0d", i), 5'(i), 5'(32 - i),
              (i == 29) ? 32'd227 : 32'd0, (i == 3) ? 32'd227 : 32'd0);
      end

      // Plain write then read.
      write(5'd5, 32'hDEAD_BEEF);
      chk("wr5_busy1", {31'd0, WriteBusy}, 32'd1);
      load("rd5", 5'd5, 5'd0, 32'hDEAD_BEEF, 32'd0);
      chk("wr5_busy0", {31'd0, WriteBusy}, 32'd0);

      // Write to register 0 is dropped.
      write(5'd0, 32'h1234_5678);
      chk("wr0_busy", {31'd0, WriteBusy}, 32'd0);
      load("rd0", 5'd0, 5'd0, 32'd0, 32'd0);

      // Same-edge write and LoadAB.
      write(5'd8, 32'h0000_0005);
      step();
`ifdef REG_BANK_WRITE_BYPASS_EN
      exp_same = 32'hAAAA_0001;
`else
      exp_same = 32'h0000_0005;
`endif
      RegWrite  = 1'b1;
      WriteReg  = 5'd8;
      WriteData = 32'hAAAA_0001;
      load("same_edge", 5'd5, 5'd8, 32'hDEAD_BEEF, exp_same);
      chk("same_busy", {31'd0, WriteBusy}, 32'd1);
      load("after_same", 5'd8, 5'd8, 32'hAAAA_0001, 32'hAAAA_0001);

      // Reset discards an in-flight write and restores the stack pointer.
      write(5'd29, 32'h0000_0100);
      RegWrite  = 1'b1;
      WriteReg  = 5'd29;
      WriteData = 32'h0000_0200;
      reset     = 1'b0;
      step();
      reset     = 1'b1;
      RegWrite  = 1'b0;
      chk("rst_wr_busy", {31'd0, WriteBusy}, 32'd0);
      load("rst_sp", 5'd29, 5'd5, 32'd227, 32'd0);

      // Back-to-back writes keep busy high for three cycles.
      RegWrite  = 1'b1;
      WriteReg  = 5'd1;
      WriteData = 32'h1111_0001;
      step();
      chk("b2b_busy1", {31'd0, WriteBusy}, 32'd1);
      WriteReg  = 5'd2;
      WriteData = 32'h2222_0002;
      step();
      chk("b2b_busy2", {31'd0, WriteBusy}, 32'd1);
      WriteReg  = 5'd3;
      WriteData = 32'h3333_0003;
      step();
      chk("b2b_busy3", {31'd0, WriteBusy}, 32'd1);
      RegWrite  = 1'b0;
      step();
      chk("b2b_busy4", {31'd0, WriteBusy}, 32'd0);
      load("b2b_rd13", 5'd1, 5'd3, 32'h1111_0001, 32'h3333_0003);

      // Latches hold while LoadAB is low.
      ReadReg1 = 5'd2;
      ReadReg2 = 5'd29;
      step();
      step();
      chk("hold_A", A, 32'h1111_0001);
      chk("hold_B", B, 32'h3333_0003);
      load("rd2", 5'd2, 5'd31, 32'h2222_0002, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
